// File: rtl/dmem_pkg.sv
// Shared constants for the dmem responder: MMIO word offsets, TXSTAT bit layout, LED width.
package dmem_pkg;

  typedef enum logic [1:0] {
    OFF_CYCLE  = 2'd0,
    OFF_LED    = 2'd1,
    OFF_TXDATA = 2'd2,
    OFF_TXSTAT = 2'd3
  } mmio_off_e;

  localparam int unsigned STAT_FULL  = 31;
  localparam int unsigned STAT_EMPTY = 30;
  localparam int unsigned STAT_OVF   = 29;
  localparam int unsigned LED_W      = 16;

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// Byte TX FIFO with registered storage, combinational head and a sticky overflow flag.
module tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_AW    = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic [7:0]         data_i,
  input  logic               ready_i,
  input  logic               clr_ovf_i,
  output logic [7:0]         tx_data_o,
  output logic               tx_valid_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               ovf_o,
  output logic [FIFO_AW:0]   count_o
);

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               pop, acc;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == (FIFO_AW+1)'(FIFO_DEPTH));
  assign pop        = ready_i && !empty_o;
  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign acc        = push_i && (!full_o || pop);
  assign tx_valid_o = !empty_o;
  assign tx_data_o  = empty_o ? '0 : mem_q[rd_q];
  assign ovf_o      = ovf_q;
  assign count_o    = cnt_q;

  always_comb begin
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    wr_d  = acc ? wr_q + 1'b1 : wr_q;
    cnt_d = cnt_q;
    case ({acc, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    ovf_d = ovf_q;
    if (clr_ovf_i)        ovf_d = 1'b0;
    if (push_i && !acc)   ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (acc) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the processor dmem port: word RAM plus CYCLE/LED/TX FIFO MMIO window.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_AW    = 3,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [15:0] led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      q_q, rd_d;
  logic [31:0]      cycle_q, cycle_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      off, stat;
  logic             in_ram, in_mmio;
  logic             push, clr_ovf;
  logic             full, empty, ovf;
  logic [FIFO_AW:0] count;
  mmio_off_e        sel;

  assign off     = address_dmem - MMIO_BASE;
  assign in_ram  = address_dmem < 32'(DEPTH);
  assign in_mmio = (off[31:2] == '0);
  assign sel     = mmio_off_e'(off[1:0]);
  assign push    = wren && in_mmio && (sel == OFF_TXDATA);
  assign clr_ovf = wren && in_mmio && (sel == OFF_TXSTAT);
  assign cycle_d = cycle_q + 32'd1;

  always_comb begin
    led_d = led_q;
    if (wren && in_mmio && (sel == OFF_LED)) led_d = data[LED_W-1:0];
  end

  always_comb begin
    stat             = '0;
    stat[STAT_FULL]  = full;
    stat[STAT_EMPTY] = empty;
    stat[STAT_OVF]   = ovf;
    stat[FIFO_AW:0]  = count;
  end

  // Every source is sampled before this edge's updates, giving read-first behaviour everywhere.
  always_comb begin
    rd_d = '0;
    if (in_ram) begin
      rd_d = mem_q[address_dmem[ADDR_W-1:0]];
    end else if (in_mmio) begin
      case (sel)
        OFF_CYCLE:  rd_d = cycle_q;
        OFF_LED:    rd_d = 32'(led_q);
        OFF_TXSTAT: rd_d = stat;
        default:    rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wren && in_ram) mem_q[address_dmem[ADDR_W-1:0]] <= data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q     <= '0;
      led_q   <= '0;
      cycle_q <= '0;
    end else begin
      q_q     <= rd_d;
      led_q   <= led_d;
      cycle_q <= cycle_d;
    end
  end

  assign q_dmem = q_q;
  assign led    = led_q;

  tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_tx_fifo (
    .clk_i      (clock),
    .rst_ni     (reset),
    .push_i     (push),
    .data_i     (data[7:0]),
    .ready_i    (tx_ready),
    .clr_ovf_i  (clr_ovf),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .full_o     (full),
    .empty_o    (empty),
    .ovf_o      (ovf),
    .count_o    (count)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, CYCLE, LED, TX FIFO and decode corner cases.
module tb_dmem_responder;

  localparam logic [31:0] MMIO = 32'hFFFF_0000;

  logic        clock;
  logic        reset;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [15:0] led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [31:0] ed;

  dmem_responder dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .led          (led),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Rising edges seen since the last reset release.
  always @(posedge clock or negedge reset) begin
    if (!reset) ed <= '0;
    else        ed <= ed + 32'd1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  initial begin
    logic ok;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0; wren = 1'b0; address_dmem = '0; data = '0; tx_ready = 1'b0;
    step(); step();
    chk("rst_q", q_dmem, 32'h0);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_txdata", {24'h0, tx_data}, 32'h0);
    reset = 1'b1;

    // RAM write then read, and read-first on same-edge read+write
    address_dmem = 32'd5; data = 32'hDEAD_BEEF; wren = 1'b1; step();
    wren = 1'b0; step();
    chk("ram_rd", q_dmem, 32'hDEAD_BEEF);
    data = 32'h1; wren = 1'b1; step();
    chk("ram_rfw_old", q_dmem, 32'hDEAD_BEEF);
    wren = 1'b0; step();
    chk("ram_rfw_new", q_dmem, 32'h1);

    // CYCLE after a fresh reset and 100 cycles, then wrap
    reset = 1'b0; #2; reset = 1'b1;
    repeat (100) step();
    address_dmem = MMIO; step();
    ok = (q_dmem == ed - 32'd1) || (q_dmem == ed);
    chk("cycle_near", {31'h0, ok}, 32'h1);
    force dut.cycle_d = 32'hFFFF_FFFF;
    step();
    release dut.cycle_d;
    step();
    chk("cycle_max", q_dmem, 32'hFFFF_FFFF);
    step();
    chk("cycle_wrap", q_dmem, 32'h0);

    // Decode holes
    address_dmem = 32'h0; data = 32'h0BAD_F00D; wren = 1'b1; step();
    wren = 1'b0; address_dmem = 32'h0000_2000; step();
    chk("oor_rd", q_dmem, 32'h0);
    address_dmem = MMIO + 32'd2; step();
    chk("txdata_rd", q_dmem, 32'h0);
    address_dmem = 32'h0000_2000; data = 32'h5555_5555; wren = 1'b1; step();
    wren = 1'b0; address_dmem = 32'h0; step();
    chk("oor_no_alias", q_dmem, 32'h0BAD_F00D);
    address_dmem = MMIO + 32'd9; step();
    chk("mmio_hole_rd", q_dmem, 32'h0);

    // LED write/readback and async reset
    address_dmem = MMIO + 32'd1; data = 32'h0001_2345; wren = 1'b1; step();
    chk("led_out", {16'h0, led}, 32'h2345);
    wren = 1'b0; step();
    chk("led_rd", q_dmem, 32'h0000_2345);
    #2; reset = 1'b0; #1;
    chk("led_async_rst", {16'h0, led}, 32'h0);
    chk("q_async_rst", q_dmem, 32'h0);
    #1; reset = 1'b1;

    // Overfill FIFO with ready low
    tx_ready = 1'b0;
    address_dmem = MMIO + 32'd2; wren = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      data = 32'(i); step();
    end
    wren = 1'b0; address_dmem = MMIO + 32'd3; step();
    chk("stat_full_ovf", q_dmem, 32'hA000_0008);
    chk("head_held", {24'h0, tx_data}, 32'h01);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_valid", {31'h0, tx_valid}, 32'h1);
      chk("drain_byte", {24'h0, tx_data}, 32'(i));
      step();
    end
    tx_ready = 1'b0;
    chk("drain_empty", {31'h0, tx_valid}, 32'h0);
    step();
    chk("stat_empty_ovf", q_dmem, 32'h6000_0000);
    wren = 1'b1; step();
    wren = 1'b0; step();
    chk("stat_cleared", q_dmem, 32'h4000_0000);

    // Full FIFO, push coinciding with pop
    address_dmem = MMIO + 32'd2; wren = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data = 32'h11 + 32'(i); step();
    end
    tx_ready = 1'b1; data = 32'hAA; step();
    wren = 1'b0; tx_ready = 1'b0; address_dmem = MMIO + 32'd3; step();
    chk("stat_push_pop_full", q_dmem, 32'h8000_0008);
    tx_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("pp_byte", {24'h0, tx_data}, 32'h12 + 32'(i));
      step();
    end
    chk("pp_last_aa", {24'h0, tx_data}, 32'hAA);
    step();
    chk("pp_empty", {31'h0, tx_valid}, 32'h0);

    // Push and ready together on an empty FIFO: push only
    address_dmem = MMIO + 32'd2; data = 32'h77; wren = 1'b1; step();
    wren = 1'b0;
    chk("empty_pp_valid", {31'h0, tx_valid}, 32'h1);
    chk("empty_pp_byte", {24'h0, tx_data}, 32'h77);
    step();
    chk("empty_pp_drained", {31'h0, tx_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
